// File: rtl/ram_arb_pkg.sv
// Shared defaults and port-tag encoding for the dual-port RAM arbiter.
package ram_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 6;
  localparam int DW_DEF   = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_tag_e;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick: first set bit of req_i searched upward from ptr_i, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          vld_o,
  output logic [PW-1:0] idx_o,
  output logic [N-1:0]  oh_o
);

  always_comb begin
    int  j;
    logic found;
    j     = 0;
    found = 1'b0;
    vld_o = 1'b0;
    idx_o = '0;
    oh_o  = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found   = 1'b1;
        vld_o   = 1'b1;
        idx_o   = PW'(j);
        oh_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter mapping up to two requesters per cycle onto a dual-port RAM.
// Define RAM_ARB_COLLISION_EN to keep port B off port A's address when either access writes.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we_req,
  input  logic [NREQ*AW-1:0] addr_req,
  input  logic [NREQ*DW-1:0] data_req,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic [AW-1:0]     addr_a,
  output logic [AW-1:0]     addr_b,
  output logic [DW-1:0]     data_a,
  output logic [DW-1:0]     data_b,
  output logic              we_a,
  output logic              we_b,
  input  logic [DW-1:0]     q_a,
  input  logic [DW-1:0]     q_b
);

  localparam int PW = ptr_width(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rd_pend_q, rd_pend_d;
  logic [NREQ-1:0] tag_q, tag_d;

  logic            a_vld, b_vld, a_go, b_go;
  logic [PW-1:0]   a_idx, b_idx;
  logic [NREQ-1:0] a_oh, b_oh, b_cand;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_data, b_data;
  logic            a_we, b_we;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick_a (
    .req_i (req),
    .ptr_i (ptr_q),
    .vld_o (a_vld),
    .idx_o (a_idx),
    .oh_o  (a_oh)
  );

  assign a_addr = addr_req[a_idx*AW +: AW];
  assign a_data = data_req[a_idx*DW +: DW];
  assign a_we   = we_req[a_idx];

  always_comb begin
    b_cand = req & ~a_oh;
`ifdef RAM_ARB_COLLISION_EN
    for (int i = 0; i < NREQ; i++) begin
      if (a_vld && (we_req[i] || a_we) && (addr_req[i*AW +: AW] == a_addr))
        b_cand[i] = 1'b0;
    end
`endif
  end

  // Starting B's scan at ptr is equivalent to starting just after A's winner.
  rr_pick #(.N(NREQ), .PW(PW)) u_pick_b (
    .req_i (b_cand),
    .ptr_i (ptr_q),
    .vld_o (b_vld),
    .idx_o (b_idx),
    .oh_o  (b_oh)
  );

  assign b_addr = addr_req[b_idx*AW +: AW];
  assign b_data = data_req[b_idx*DW +: DW];
  assign b_we   = we_req[b_idx];

  assign a_go = a_vld & ~rst;
  assign b_go = b_vld & ~rst;

  always_comb begin
    gnt    = '0;
    addr_a = '0;
    data_a = '0;
    we_a   = 1'b0;
    addr_b = '0;
    data_b = '0;
    we_b   = 1'b0;
    if (a_go) begin
      gnt    = gnt | a_oh;
      addr_a = a_addr;
      data_a = a_data;
      we_a   = a_we;
    end
    if (b_go) begin
      gnt    = gnt | b_oh;
      addr_b = b_addr;
      data_b = b_data;
      we_b   = b_we;
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    rd_pend_d = '0;
    tag_d     = tag_q;
    if (a_go) begin
      ptr_d = (int'(a_idx) == NREQ - 1) ? '0 : a_idx + PW'(1);
      if (!a_we) begin
        rd_pend_d[a_idx] = 1'b1;
        tag_d[a_idx]     = PORT_A;
      end
    end
    if (b_go && !b_we) begin
      rd_pend_d[b_idx] = 1'b1;
      tag_d[b_idx]     = PORT_B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      rd_pend_q <= '0;
      tag_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      tag_q     <= tag_d;
    end
  end

  // The RAM registers its output, so q_x is valid in the cycle after issue.
  assign rvalid = rd_pend_q;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rd_pend_q[i])
        rdata[i*DW +: DW] = (tag_q[i] == PORT_B) ? q_b : q_a;
    end
  end

endmodule
